// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory bus between fetch and MEM-stage accesses,
// serving data first and freezing the pipeline while an access is outstanding.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    input  logic                mem_req,
    input  logic                mem_we,
    input  logic [ADDR_W-1:0]   mem_addr,
    input  logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W/8-1:0] mem_be,
    output logic                bus_req,
    output logic                bus_we,
    output logic [ADDR_W-1:0]   bus_addr,
    output logic [DATA_W-1:0]   bus_wdata,
    output logic [DATA_W/8-1:0] bus_be,
    input  logic                bus_ack,
    input  logic [DATA_W-1:0]   bus_rdata,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_valid,
    output logic [DATA_W-1:0]   mem_rdata,
    output logic                mem_valid,
    output logic                stall_all,
    output logic                bus_error
);
    typedef enum logic [1:0] {IDLE, DATA_WAIT, FETCH_WAIT, RELEASE} state_t;
    state_t              r_state;
    logic [7:0]          r_cnt;
    logic                r_did_mem;
    logic                r_bus_we;
    logic [ADDR_W-1:0]   r_bus_addr;
    logic [DATA_W-1:0]   r_bus_wdata;
    logic [DATA_W/8-1:0] r_bus_be;
    logic [DATA_W-1:0]   r_if_rdata;
    logic [DATA_W-1:0]   r_mem_rdata;
    logic                r_if_valid;
    logic                r_mem_valid;
    logic                r_err;
    logic                w_wait;
    logic                w_done;
    logic [DATA_W-1:0]   w_rd;

    assign w_wait    = (r_state == DATA_WAIT) | (r_state == FETCH_WAIT);
    // ack wins over a simultaneous timeout; a timed-out access returns zero
    assign w_done    = w_wait & (bus_ack | (r_cnt == 8'(TIMEOUT)));
    assign w_rd      = bus_ack ? bus_rdata : '0;
    assign bus_req   = w_wait;
    assign bus_we    = r_bus_we;
    assign bus_addr  = r_bus_addr;
    assign bus_wdata = r_bus_wdata;
    assign bus_be    = r_bus_be;
    assign if_rdata  = r_if_rdata;
    assign mem_rdata = r_mem_rdata;
    assign if_valid  = r_if_valid;
    assign mem_valid = r_mem_valid;
    assign bus_error = r_err;
    assign stall_all = !reset & (((r_state == IDLE) & (if_req | mem_req)) | w_wait);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_did_mem   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_wdata <= '0;
            r_bus_be    <= '0;
            r_if_rdata  <= '0;
            r_mem_rdata <= '0;
            r_if_valid  <= 1'b0;
            r_mem_valid <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    if (mem_req) begin
                        r_state     <= DATA_WAIT;
                        r_did_mem   <= 1'b1;
                        r_bus_we    <= mem_we;
                        r_bus_addr  <= mem_addr;
                        r_bus_wdata <= mem_wdata;
                        r_bus_be    <= mem_be;
                    end else if (if_req) begin
                        r_state    <= FETCH_WAIT;
                        r_did_mem  <= 1'b0;
                        r_bus_we   <= 1'b0;
                        r_bus_addr <= if_addr;
                        r_bus_be   <= '1;
                    end
                end
                DATA_WAIT: begin
                    if (w_done) begin
                        if (!r_bus_we) r_mem_rdata <= w_rd;
                        if (!bus_ack) r_err <= 1'b1;
                        r_cnt <= '0;
                        if (if_req) begin
                            r_state    <= FETCH_WAIT;
                            r_bus_we   <= 1'b0;
                            r_bus_addr <= if_addr;
                            r_bus_be   <= '1;
                        end else begin
                            r_state     <= RELEASE;
                            r_mem_valid <= 1'b1;
                        end
                    end else r_cnt <= r_cnt + 8'd1;
                end
                FETCH_WAIT: begin
                    if (w_done) begin
                        r_if_rdata  <= w_rd;
                        if (!bus_ack) r_err <= 1'b1;
                        r_cnt       <= '0;
                        r_state     <= RELEASE;
                        r_if_valid  <= 1'b1;
                        r_mem_valid <= r_did_mem;
                    end else r_cnt <= r_cnt + 8'd1;
                end
                default: begin
                    r_state     <= IDLE;
                    r_if_valid  <= 1'b0;
                    r_mem_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: randomized and directed checks of the arbiter against
// a transaction-level model (access list, wait counts, expected release data).
module tb_mem_port_arbiter;
    localparam int TO = 255;
    logic        clk = 0, reset = 1;
    logic        if_req = 0, mem_req = 0, mem_we = 0, bus_ack = 0;
    logic [31:0] if_addr = 0, mem_addr = 0, mem_wdata = 0, bus_rdata = 0;
    logic [3:0]  mem_be = 0;
    logic        bus_req, bus_we, if_valid, mem_valid, stall_all, bus_error;
    logic [31:0] bus_addr, bus_wdata, if_rdata, mem_rdata;
    logic [3:0]  bus_be;
    int          total = 0, bad = 0;
    logic [31:0] m_mem = 0, m_if = 0;
    logic        m_err = 0;

    mem_port_arbiter dut (
        .clk(clk), .reset(reset), .if_req(if_req), .if_addr(if_addr),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be), .bus_req(bus_req),
        .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_be(bus_be), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
        .if_rdata(if_rdata), .if_valid(if_valid), .mem_rdata(mem_rdata),
        .mem_valid(mem_valid), .stall_all(stall_all), .bus_error(bus_error)
    );

    always #5 clk = ~clk;

    // w < 0 means the responder never acks, so the access must time out
    task automatic run_txn(input bit mr, input bit ir, input bit we, input logic [31:0] ma,
                           input logic [31:0] ia, input logic [31:0] wd, input logic [3:0] be,
                           input int dw, input int fw, input logic [31:0] dr, input logic [31:0] fr);
        logic [31:0] a_addr[2], a_rd[2];
        logic        a_we[2], a_data[2];
        logic [3:0]  a_be[2];
        int          a_w[2];
        int          n = 0, len, stalls = 0;
        if (mr) begin a_addr[n] = ma; a_we[n] = we; a_be[n] = be; a_w[n] = dw; a_rd[n] = dr; a_data[n] = 1; n++; end
        if (ir) begin a_addr[n] = ia; a_we[n] = 0; a_be[n] = 4'hF; a_w[n] = fw; a_rd[n] = fr; a_data[n] = 0; n++; end
        @(negedge clk);
        mem_req = mr; if_req = ir; mem_we = we; mem_addr = ma; if_addr = ia;
        mem_wdata = wd; mem_be = be; bus_ack = 0;
        #1;
        if (stall_all) stalls++;
        total++; if (bus_req !== 1'b0) begin bad++; $display("FAIL idle_busreq got=%0b exp=0", bus_req); end
        for (int k = 0; k < n; k++) begin
            len = (a_w[k] < 0) ? TO + 1 : a_w[k] + 1;
            for (int c = 0; c < len; c++) begin
                @(negedge clk);
                bus_ack = (c == a_w[k]);
                bus_rdata = (c == a_w[k]) ? a_rd[k] : $urandom;
                #1;
                if (stall_all) stalls++;
                total++; if (bus_req !== 1'b1) begin bad++; $display("FAIL wait_busreq acc=%0d cyc=%0d got=%0b exp=1", k, c, bus_req); end
                total++; if (bus_addr !== a_addr[k] || bus_we !== a_we[k] || bus_be !== a_be[k])
                    begin bad++; $display("FAIL bus_regs acc=%0d cyc=%0d got=%h/%0b/%h exp=%h/%0b/%h", k, c, bus_addr, bus_we, bus_be, a_addr[k], a_we[k], a_be[k]); end
                if (a_data[k] && a_we[k]) begin
                    total++; if (bus_wdata !== wd) begin bad++; $display("FAIL bus_wdata cyc=%0d got=%h exp=%h", c, bus_wdata, wd); end
                end
            end
            if (a_w[k] < 0) m_err = 1;
            if (a_data[k] && !a_we[k]) m_mem = (a_w[k] < 0) ? 32'h0 : a_rd[k];
            if (!a_data[k]) m_if = (a_w[k] < 0) ? 32'h0 : a_rd[k];
        end
        @(negedge clk);
        mem_req = 0; if_req = 0; bus_ack = 1; bus_rdata = $urandom;
        #1;
        total++; if (stalls !== 1 + (mr ? ((dw < 0 ? TO : dw) + 1) : 0) + (ir ? ((fw < 0 ? TO : fw) + 1) : 0))
            begin bad++; $display("FAIL stall_count got=%0d", stalls); end
        total++; if (stall_all !== 1'b0 || bus_req !== 1'b0) begin bad++; $display("FAIL rel_stall got=%0b/%0b exp=0/0", stall_all, bus_req); end
        total++; if (mem_valid !== mr || if_valid !== ir) begin bad++; $display("FAIL rel_valid got=%0b/%0b exp=%0b/%0b", mem_valid, if_valid, mr, ir); end
        total++; if (mem_rdata !== m_mem) begin bad++; $display("FAIL mem_rdata got=%h exp=%h", mem_rdata, m_mem); end
        total++; if (if_rdata !== m_if) begin bad++; $display("FAIL if_rdata got=%h exp=%h", if_rdata, m_if); end
        total++; if (bus_error !== m_err) begin bad++; $display("FAIL bus_error got=%0b exp=%0b", bus_error, m_err); end
        @(negedge clk);
        #1;
        total++; if (mem_valid !== 1'b0 || if_valid !== 1'b0 || bus_req !== 1'b0 || stall_all !== 1'b0)
            begin bad++; $display("FAIL post_release got=%0b/%0b/%0b/%0b exp=0/0/0/0", mem_valid, if_valid, bus_req, stall_all); end
        bus_ack = 0;
    endtask

    task automatic test_reset();
        if_req = 1; mem_req = 1;
        #1;
        total++; if (stall_all !== 1'b0) begin bad++; $display("FAIL reset_stall got=%0b exp=0", stall_all); end
        total++; if ({bus_req, if_valid, mem_valid, bus_error, bus_we} !== 5'b0 || bus_addr !== 0 || bus_wdata !== 0 || bus_be !== 0 || if_rdata !== 0 || mem_rdata !== 0)
            begin bad++; $display("FAIL reset_outs got=%0b%0b%0b%0b %h %h", bus_req, if_valid, mem_valid, bus_error, if_rdata, mem_rdata); end
        @(negedge clk);
        if_req = 0; mem_req = 0; reset = 0;
    endtask

    task automatic test_idle();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus_ack = i[0]; bus_rdata = $urandom;
            #1;
            total++; if (stall_all !== 1'b0 || bus_req !== 1'b0 || mem_valid !== 1'b0 || if_valid !== 1'b0)
                begin bad++; $display("FAIL idle cyc=%0d got=%0b/%0b/%0b/%0b", i, stall_all, bus_req, mem_valid, if_valid); end
        end
        bus_ack = 0;
    endtask

    task automatic test_fetch_only();
        run_txn(0, 1, 0, 32'h0, 32'h100, 32'h0, 4'h0, 0, 0, 32'h0, 32'h00500093);
    endtask

    task automatic test_load_fetch();
        run_txn(1, 1, 0, 32'h2000, 32'h104, 32'h0, 4'hF, 0, 0, 32'h12345678, 32'h00A00113);
    endtask

    task automatic test_store_wait();
        run_txn(1, 0, 1, 32'h3000, 32'h0, 32'hDEADBEEF, 4'h3, 3, 0, 32'hFFFF0000, 32'h0);
    endtask

    task automatic test_random();
        for (int t = 0; t < 30; t++) begin
            bit mr, ir;
            mr = $urandom_range(0, 1);
            ir = mr ? 1'($urandom_range(0, 1)) : 1'b1;
            run_txn(mr, ir, 1'($urandom_range(0, 1)), $urandom, $urandom, $urandom, 4'($urandom),
                    $urandom_range(0, 3), $urandom_range(0, 3), $urandom, $urandom);
        end
    endtask

    task automatic test_ack_at_timeout();
        run_txn(1, 0, 0, 32'h4000, 32'h0, 32'h0, 4'hF, TO, 0, 32'hCAFEF00D, 32'h0);
    endtask

    task automatic test_timeout();
        run_txn(0, 1, 0, 32'h0, 32'h200, 32'h0, 4'h0, 0, -1, 32'h0, 32'h0);
        run_txn(1, 1, 0, 32'h5000, 32'h204, 32'h0, 4'hF, 1, 0, 32'h11112222, 32'h33334444);
    endtask

    task automatic test_reset_mid_access();
        @(negedge clk);
        mem_req = 1; mem_we = 0; mem_addr = 32'h6000; mem_be = 4'hF;
        @(negedge clk);
        bus_ack = 0;
        #1;
        total++; if (bus_req !== 1'b1) begin bad++; $display("FAIL mid_busreq got=%0b exp=1", bus_req); end
        reset = 1;
        #1;
        total++; if (bus_req !== 1'b0 || stall_all !== 1'b0 || bus_error !== 1'b0)
            begin bad++; $display("FAIL mid_reset got=%0b/%0b/%0b exp=0/0/0", bus_req, stall_all, bus_error); end
        @(negedge clk);
        reset = 0; mem_req = 0; if_req = 0;
        m_mem = 0; m_if = 0; m_err = 0;
        @(negedge clk);
        bus_ack = 1; bus_rdata = 32'hBAD0BAD0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus_ack = 0;
            #1;
            total++; if (mem_valid !== 1'b0 || bus_req !== 1'b0 || mem_rdata !== m_mem)
                begin bad++; $display("FAIL late_ack cyc=%0d got=%0b/%0b/%h exp=0/0/%h", i, mem_valid, bus_req, mem_rdata, m_mem); end
        end
        run_txn(1, 0, 0, 32'h7000, 32'h0, 32'h0, 4'hF, 2, 0, 32'h0BADCAFE, 32'h0);
    endtask

    initial begin
        test_reset();
        test_idle();
        test_fetch_only();
        test_load_fetch();
        test_store_wait();
        test_random();
        test_ack_at_timeout();
        test_timeout();
        test_reset_mid_access();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter ADDR_W, 32, address width of fetch, data and bus ports.
REQ-002 Parameter DATA_W, 32, data width; byte enables are DATA_W/8 bits.
REQ-003 Parameter TIMEOUT, 255, maximum wait cycles for bus_ack before an access is abandoned; the counter is 8 bits.
REQ-004 Port: clk, in, 1, single clock; all state updates on its rising edge.
REQ-005 Port: reset, in, 1, asynchronous, active-high.
REQ-006 Ports: if_req in 1 and if_addr in ADDR_W; the fetch stage requests an instruction.
REQ-007 Ports: mem_req in 1, mem_we in 1, mem_addr in ADDR_W, mem_wdata in DATA_W and mem_be in DATA_W/8; the MEM-stage load or store.
REQ-008 Ports: bus_req out 1, bus_we out 1, bus_addr out ADDR_W, bus_wdata out DATA_W, bus_be out DATA_W/8; the single shared memory port.
REQ-009 Ports: bus_ack in 1 and bus_rdata in DATA_W; completion and read data.
REQ-010 Ports: if_rdata out DATA_W and if_valid out 1; the fetched instruction and its release strobe.
REQ-011 Ports: mem_rdata out DATA_W and mem_valid out 1; the load data and its release strobe.
REQ-012 Port: stall_all, out, 1; freezes every pipeline stage through the hazard unit.
REQ-013 Port: bus_error, out, 1; sticky flag indicating a timeout occurred.

Function
REQ-014 The FSM SHALL have four states:
- IDLE
- DATA_WAIT
- FETCH_WAIT
- RELEASE
REQ-015 Transitions out of IDLE SHALL be:
- mem_req=1: go to DATA_WAIT, latching the mem_* inputs into the bus registers.
- else if_req=1: go to FETCH_WAIT, latching if_addr with bus_we=0 and bus_be all ones.
- else: stay in IDLE.
REQ-016 DATA_WAIT on completion SHALL go to FETCH_WAIT when if_req=1, latching the fetch access at that point; otherwise it SHALL go to RELEASE.
REQ-017 FETCH_WAIT on completion SHALL go to RELEASE.
REQ-018 RELEASE SHALL last exactly one cycle and then go to IDLE unconditionally.
REQ-019 Completion SHALL mean bus_ack=1 in a WAIT state, or a timeout.
REQ-020 Data SHALL always be served before fetch when both are requested, because the data access belongs to the older instruction.
REQ-021 bus_req SHALL equal 1 exactly while in DATA_WAIT or FETCH_WAIT; all other bus outputs SHALL come from registers that stay stable throughout a WAIT state.
REQ-022 bus_ack SHALL be ignored in IDLE and RELEASE.
REQ-023 An ack in the first cycle of a WAIT state SHALL be accepted, giving zero wait states.
REQ-024 stall_all SHALL be combinational and equal (!reset) & ((IDLE & (if_req|mem_req)) | DATA_WAIT | FETCH_WAIT).
REQ-025 stall_all SHALL be 0 in RELEASE so the pipeline advances exactly one step.
REQ-026 When a load completes, bus_rdata SHALL be captured into mem_rdata; a store SHALL leave mem_rdata unchanged.
REQ-027 When a fetch completes, bus_rdata SHALL be captured into if_rdata.
REQ-028 Both data registers SHALL hold their values until the next capture.
REQ-029 if_valid and mem_valid SHALL be 1 only in RELEASE, and only for the port(s) served in the current transaction.
REQ-030 The timeout counter SHALL clear on entry to each WAIT state and increment each WAIT cycle without ack.
REQ-031 When the counter reaches TIMEOUT, the access SHALL complete with captured data 0 and bus_error SHALL be set.
REQ-032 bus_error SHALL be cleared only by reset.
REQ-033 If ack and timeout occur in the same cycle, ack SHALL win: real data is captured and no error is flagged.
REQ-034 Requesters SHALL hold their request inputs stable while stall_all=1.
REQ-035 Requests that change in IDLE without being accepted SHALL have no effect.
REQ-036 Minimum latencies with zero wait states:
- Single access: 2 stall cycles, then RELEASE.
- Data plus fetch: 3 stall cycles, then RELEASE.

Reset
REQ-037 Reset assertion SHALL asynchronously force:
- state IDLE;
- bus_req=0, if_valid=0, mem_valid=0, bus_error=0;
- the timeout counter to 0;
- all data and bus registers to 0.
REQ-038 A reset during a WAIT state SHALL abandon the access immediately; a late bus_ack after reset releases SHALL be ignored in IDLE.
REQ-039 stall_all SHALL be 0 while reset is asserted; pipeline stalls during reset are supplied by the hazard unit.

Verification
REQ-040 Fetch only: if_req=1, if_addr=0x100, ack on the first WAIT cycle with rdata 0x00500093 -> stall_all=1 for 2 cycles, then RELEASE with if_valid=1, if_rdata=0x00500093, mem_valid=0.
REQ-041 Load and fetch together: mem_addr=0x2000, if_addr=0x104, zero-wait acks -> bus_addr is 0x2000 then 0x104; stall_all=1 for 3 cycles; RELEASE has both valid strobes high.
REQ-042 Store with 3 wait states: mem_we=1, mem_be=0x3, mem_wdata=0xDEADBEEF -> bus_we=1, bus_be=0x3 and bus_wdata stable for 4 bus_req cycles; mem_rdata unchanged.
REQ-043 Timeout: bus_ack never asserted -> after 255 WAIT cycles the access completes with rdata 0 and bus_error=1, which stays set until reset.
REQ-044 Reset mid-access: assert reset in DATA_WAIT -> bus_req=0 in the same cycle; state IDLE; an ack arriving one cycle after reset release does not raise mem_valid.
REQ-045 Idle: if_req=0 and mem_req=0 for 10 cycles -> stall_all=0 and bus_req=0 throughout.
